// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
// Single-bus 32-bit CPU datapath for the lab processor. An external control
// unit sequences it one cycle at a time: one-hot *out strobes choose the bus
// source, and *in strobes choose which registers load at the next rising edge.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous active-high reset; clears every register
//                       and overrides all load strobes in that cycle
//   PCout .. R4out      bus source select
//                       (priority MDR > Zlo > PC > R2 > R4; bus = 0 when idle)
//   MARin, PCin, IRin,
//   Yin, R2in, R4in,
//   R5in                load the named register from the bus
//   MDRin               load MDR; read picks Mdatain (1) or the bus (0)
//   read                MDR source select, only meaningful together with MDRin
//   Zin                 load Zhi/Zlo from the ALU result
//   AND, IncPC          ALU op select (AND has priority over IncPC)
//   Mdatain             memory read data
//   BusMuxOut           current bus value
//   *_q                 register contents, for observation
// -----------------------------------------------------------------------------
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    // bus source strobes
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R4out,

    // register load strobes
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R5in,
    input  logic             R2in,
    input  logic             R4in,

    // ALU / memory controls
    input  logic             IncPC,
    input  logic             read,
    input  logic             AND,
    input  logic [WIDTH-1:0] Mdatain,

    // observation
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] MDR_q,
    output logic [WIDTH-1:0] Y_q,
    output logic [WIDTH-1:0] R2_q,
    output logic [WIDTH-1:0] R4_q,
    output logic [WIDTH-1:0] R5_q,
    output logic [WIDTH-1:0] Zlo_q,
    output logic [WIDTH-1:0] Zhi_q
);

    // -------------------------------------------------------------------------
    // Registers that can only load from the bus share one structure: a bank of
    // identical load-enabled registers indexed by the constants below.
    // -------------------------------------------------------------------------
    localparam int NUM_BANK = 7;
    localparam int IDX_PC   = 0;
    localparam int IDX_IR   = 1;
    localparam int IDX_MAR  = 2;
    localparam int IDX_Y    = 3;
    localparam int IDX_R2   = 4;
    localparam int IDX_R4   = 5;
    localparam int IDX_R5   = 6;

    logic [NUM_BANK-1:0]            bank_load;
    logic [NUM_BANK-1:0][WIDTH-1:0] bank_reg;

    logic [WIDTH-1:0]   mdr_reg;
    logic [WIDTH-1:0]   mdr_next;
    logic [WIDTH-1:0]   zhi_reg;
    logic [WIDTH-1:0]   zlo_reg;
    logic [2*WIDTH-1:0] alu_result;
    logic [WIDTH-1:0]   bus_value;

    // Load strobe for each bank entry, in index order.
    always_comb begin
        bank_load          = '0;
        bank_load[IDX_PC]  = PCin;
        bank_load[IDX_IR]  = IRin;
        bank_load[IDX_MAR] = MARin;
        bank_load[IDX_Y]   = Yin;
        bank_load[IDX_R2]  = R2in;
        bank_load[IDX_R4]  = R4in;
        bank_load[IDX_R5]  = R5in;
    end

    // -------------------------------------------------------------------------
    // Bus multiplexer. Control should assert one source at a time; the fixed
    // priority only makes an accidental overlap deterministic. Sources are
    // registers, so the bus always carries pre-edge values, which is what gives
    // read-before-write when a register is both source and destination.
    // -------------------------------------------------------------------------
    always_comb begin
        bus_value = '0;
        if (MDRout) begin
            bus_value = mdr_reg;
        end else if (Zlowout) begin
            bus_value = zlo_reg;
        end else if (PCout) begin
            bus_value = bank_reg[IDX_PC];
        end else if (R2out) begin
            bus_value = bank_reg[IDX_R2];
        end else if (R4out) begin
            bus_value = bank_reg[IDX_R4];
        end
    end

    assign BusMuxOut = bus_value;

    // -------------------------------------------------------------------------
    // ALU. The 64-bit result width exists for the Z pair; neither operation
    // produces anything in the upper half. The increment is computed at WIDTH
    // bits so an all-ones bus wraps to zero instead of carrying into Zhi.
    // -------------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        if (AND) begin
            alu_result[WIDTH-1:0] = bank_reg[IDX_Y] & bus_value;
        end else if (IncPC) begin
            alu_result[WIDTH-1:0] = bus_value + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // MDR source: memory data on a read, otherwise the bus.
    always_comb begin
        mdr_next = mdr_reg;
        if (MDRin) begin
            mdr_next = read ? Mdatain : bus_value;
        end
    end

    // -------------------------------------------------------------------------
    // Bus-loaded register bank.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (reset) begin
                    bank_reg[gi] <= '0;
                end else if (bank_load[gi]) begin
                    bank_reg[gi] <= bus_value;
                end
            end
        end
    endgenerate

    // MDR
    always_ff @(posedge clk) begin
        if (reset) begin
            mdr_reg <= '0;
        end else begin
            mdr_reg <= mdr_next;
        end
    end

    // Z pair, loaded together from the ALU result.
    always_ff @(posedge clk) begin
        if (reset) begin
            zhi_reg <= '0;
            zlo_reg <= '0;
        end else if (Zin) begin
            zhi_reg <= alu_result[2*WIDTH-1:WIDTH];
            zlo_reg <= alu_result[WIDTH-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Observation outputs
    // -------------------------------------------------------------------------
    assign PC_q  = bank_reg[IDX_PC];
    assign IR_q  = bank_reg[IDX_IR];
    assign MAR_q = bank_reg[IDX_MAR];
    assign Y_q   = bank_reg[IDX_Y];
    assign R2_q  = bank_reg[IDX_R2];
    assign R4_q  = bank_reg[IDX_R4];
    assign R5_q  = bank_reg[IDX_R5];
    assign MDR_q = mdr_reg;
    assign Zlo_q = zlo_reg;
    assign Zhi_q = zhi_reg;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
// Directed-vector bench for datapath. Each step applies one set of control
// strobes for a single clock cycle. The expected values are hand-computed
// constants, and every comparison goes through check_value.
// -----------------------------------------------------------------------------
module tb_datapath;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             PCout, Zlowout, MDRout, R2out, R4out;
    logic             MARin, Zin, PCin, MDRin, IRin, Yin, R5in, R2in, R4in;
    logic             IncPC, read, AND;
    logic [WIDTH-1:0] Mdatain;
    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] PC_q, IR_q, MAR_q, MDR_q, Y_q, R2_q, R4_q, R5_q, Zlo_q, Zhi_q;

    int checks_cnt;
    int failures_cnt;
    int cycle_cnt;

    datapath #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .MDRout    (MDRout),
        .R2out     (R2out),
        .R4out     (R4out),
        .MARin     (MARin),
        .Zin       (Zin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .R5in      (R5in),
        .R2in      (R2in),
        .R4in      (R4in),
        .IncPC     (IncPC),
        .read      (read),
        .AND       (AND),
        .Mdatain   (Mdatain),
        .BusMuxOut (BusMuxOut),
        .PC_q      (PC_q),
        .IR_q      (IR_q),
        .MAR_q     (MAR_q),
        .MDR_q     (MDR_q),
        .Y_q       (Y_q),
        .R2_q      (R2_q),
        .R4_q      (R4_q),
        .R5_q      (R5_q),
        .Zlo_q     (Zlo_q),
        .Zhi_q     (Zhi_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_strobes();
        PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R4out = 0;
        MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
        R5in = 0; R2in = 0; R4in = 0; IncPC = 0; read = 0; AND = 0;
    endtask

    // Apply the current strobes across one rising edge, then settle 1 time unit
    // past the edge so the register outputs are sampled away from it.
    task automatic step(input string what);
        @(posedge clk);
        #1;
        cycle_cnt++;
        $display("cycle %0d %s: bus=0x%08h PC=0x%08h MDR=0x%08h Zlo=0x%08h",
                 cycle_cnt, what, BusMuxOut, PC_q, MDR_q, Zlo_q);
        clear_strobes();
    endtask

    initial begin
        checks_cnt   = 0;
        failures_cnt = 0;
        cycle_cnt    = 0;

        // ---- Reset with every strobe high: reset must win ----
        PCout = 1; Zlowout = 1; MDRout = 1; R2out = 1; R4out = 1;
        MARin = 1; Zin = 1; PCin = 1; MDRin = 1; IRin = 1; Yin = 1;
        R5in = 1; R2in = 1; R4in = 1; IncPC = 1; read = 1; AND = 1;
        Mdatain = 32'hFFFF_FFFF;
        reset = 1;
        step("reset");
        reset = 0;
        check_value("rst_pc",  PC_q,  32'h0);
        check_value("rst_ir",  IR_q,  32'h0);
        check_value("rst_mar", MAR_q, 32'h0);
        check_value("rst_mdr", MDR_q, 32'h0);
        check_value("rst_y",   Y_q,   32'h0);
        check_value("rst_r2",  R2_q,  32'h0);
        check_value("rst_r4",  R4_q,  32'h0);
        check_value("rst_r5",  R5_q,  32'h0);
        check_value("rst_zlo", Zlo_q, 32'h0);
        check_value("rst_zhi", Zhi_q, 32'h0);
        #1 check_value("idle_bus", BusMuxOut, 32'h0);

        // ---- Register loads through MDR ----
        Mdatain = 32'h22; read = 1; MDRin = 1; step("mdr<=mem");
        check_value("mdr_22", MDR_q, 32'h22);
        MDRout = 1; R2in = 1; step("r2<=mdr");
        check_value("r2_load", R2_q, 32'h22);

        Mdatain = 32'h24; read = 1; MDRin = 1; step("mdr<=mem");
        MDRout = 1; R4in = 1; step("r4<=mdr");
        check_value("r4_load", R4_q, 32'h24);

        Mdatain = 32'h26; read = 1; MDRin = 1; step("mdr<=mem");
        MDRout = 1; R5in = 1; step("r5<=mdr");
        check_value("r5_load", R5_q, 32'h26);

        // ---- Instruction fetch, PC starts at 0 ----
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step("T0");
        check_value("t0_mar", MAR_q, 32'h0);
        check_value("t0_zlo", Zlo_q, 32'h1);
        check_value("t0_zhi", Zhi_q, 32'h0);

        Zlowout = 1; PCin = 1; read = 1; MDRin = 1; Mdatain = 32'h4A92_0000;
        step("T1");
        check_value("t1_pc",  PC_q,  32'h1);
        check_value("t1_mdr", MDR_q, 32'h4A92_0000);

        MDRout = 1; IRin = 1; step("T2");
        check_value("t2_ir", IR_q, 32'h4A92_0000);

        // ---- AND sequence ----
        R2out = 1; Yin = 1; step("T3");
        check_value("t3_y", Y_q, 32'h22);
        R4out = 1; AND = 1; Zin = 1; step("T4");
        check_value("t4_zlo", Zlo_q, 32'h20);
        check_value("t4_zhi", Zhi_q, 32'h0);
        Zlowout = 1; R5in = 1; step("T5");
        check_value("t5_r5", R5_q, 32'h20);

        // ---- Read-before-write: PC as source and destination ----
        PCout = 1; PCin = 1; IncPC = 1; Zin = 1; step("pc_rbw");
        check_value("rbw_pc",  PC_q,  32'h1);
        check_value("rbw_zlo", Zlo_q, 32'h2);

        // ---- Increment wrap ----
        Mdatain = 32'hFFFF_FFFF; read = 1; MDRin = 1; step("mdr<=mem");
        MDRout = 1; PCin = 1; step("pc<=mdr");
        check_value("wrap_pc", PC_q, 32'hFFFF_FFFF);
        PCout = 1; IncPC = 1; Zin = 1;
        #1 check_value("wrap_bus", BusMuxOut, 32'hFFFF_FFFF);
        step("pc+1 wrap");
        check_value("wrap_zlo", Zlo_q, 32'h0);
        check_value("wrap_zhi", Zhi_q, 32'h0);

        // ---- AND has priority over IncPC (Y=0x22, R4=0x24) ----
        R4out = 1; AND = 1; IncPC = 1; Zin = 1; step("and+inc");
        check_value("prio_alu", Zlo_q, 32'h20);

        // ---- Z holds without Zin ----
        R4out = 1; IncPC = 1; step("no zin");
        check_value("z_hold", Zlo_q, 32'h20);

        // ---- Bus priority (MDR=FFFFFFFF, Zlo=20, PC=FFFFFFFF, R2=22, R4=24) ----
        MDRout = 1; R2out = 1;
        #1 check_value("prio_mdr_r2", BusMuxOut, 32'hFFFF_FFFF);
        clear_strobes(); Zlowout = 1; PCout = 1;
        #1 check_value("prio_z_pc", BusMuxOut, 32'h20);
        clear_strobes(); R2out = 1; R4out = 1;
        #1 check_value("prio_r2_r4", BusMuxOut, 32'h22);
        clear_strobes(); R4out = 1;
        #1 check_value("bus_r4", BusMuxOut, 32'h24);
        clear_strobes();

        // ---- MDR from the bus, and read alone has no effect ----
        R4out = 1; MDRin = 1; read = 0; Mdatain = 32'h55; step("mdr<=bus");
        check_value("mdr_bus", MDR_q, 32'h24);
        read = 1; MDRin = 0; Mdatain = 32'h77; step("read only");
        check_value("mdr_hold", MDR_q, 32'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
